// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encodings,
// cause codes, status/pending bit positions and WARL masks.
package csr_pkg;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MIE           = 12'h304;
   localparam logic [11:0] CSR_MTVEC         = 12'h305;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;
   localparam logic [11:0] CSR_MTVAL         = 12'h343;
   localparam logic [11:0] CSR_MIP           = 12'h344;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_TIME          = 12'hC01;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_TIMEH         = 12'hC81;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
   localparam logic [11:0] CSR_MHARTID       = 12'hF14;

   localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

   localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
   localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
   localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;
   localparam int unsigned MIP_MSIP       = 3;
   localparam int unsigned MIP_MTIP       = 7;
   localparam int unsigned MIP_MEIP       = 11;

   localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;
   localparam logic [31:0] MIE_MASK     = 32'h0000_0888;

   function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                input logic [31:0] old_val,
                                                input logic [31:0] wsrc);
      case (op)
         CSR_OP_RW: return wsrc;
         CSR_OP_RS: return old_val | wsrc;
         CSR_OP_RC: return old_val & ~wsrc;
         default:   return old_val;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter.sv
// One performance counter of COUNTER_W bits, zero-extended to 64 on output.
// A write to either half replaces the increment for the whole counter that cycle.
module csr_counter #(
   parameter int unsigned COUNTER_W = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_inhibit,
   input  logic        i_inc,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [31:0] i_wdata,
   output logic [63:0] o_value
);

   logic [COUNTER_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_wr_lo || i_wr_hi) begin
         if (i_wr_lo) r_count[31:0] <= i_wdata;
         if (i_wr_hi) r_count[COUNTER_W-1:32] <= i_wdata[COUNTER_W-33:0];
      end else if (i_inc && !i_inhibit) begin
         r_count <= r_count + COUNTER_W'(1);
      end
   end

   assign o_value = 64'(r_count);

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap/mret sequencing, interrupt arbitration and counters.
// Define CSR_HPM_EN to implement mhpmcounter3+/mhpmevent3+; otherwise they read 0.
module csr_unit
   import csr_pkg::*;
#(
   parameter int unsigned HART_ID     = 0,
   parameter int unsigned NUM_HPM     = 4,
   parameter int unsigned COUNTER_W   = 64,
   parameter bit          VECTORED_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_valid,
   input  logic [11:0] csr_addr,
   input  logic [1:0]  csr_op,
   input  logic [31:0] csr_wsrc,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   input  logic        trap_taken,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_tval,
   input  logic        mret_taken,
   input  logic        retire_inst,
   input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event,
   input  logic        timer_irq,
   input  logic        software_irq,
   input  logic        external_irq,
   output logic        interrupt_pending,
   output logic [31:0] interrupt_cause,
   output logic [31:0] trap_vector,
   output logic [31:0] mepc_out
);

   localparam logic [31:0] INHIBIT_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

   logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
   logic [31:0] r_mcountinhibit;
   logic [63:0] w_mcycle, w_minstret;
   logic [63:0] w_hpm_val [8];
   logic [31:0] w_hpm_evt [8];
   logic [31:0] w_rd, w_new, w_mtvec_new, w_mip, w_pend, w_base;
   logic [4:0]  w_hpm_num;
   logic [2:0]  w_hpm_sel;
   logic        w_hpm_ok, w_impl, w_we, w_wr;

   assign w_mip = (32'(software_irq) << MIP_MSIP) | (32'(timer_irq) << MIP_MTIP)
                | (32'(external_irq) << MIP_MEIP);

   assign w_hpm_num = csr_addr[4:0];
   assign w_hpm_ok  = (w_hpm_num >= 5'd3) && (32'(w_hpm_num) < NUM_HPM + 32'd3);
   assign w_hpm_sel = 3'(w_hpm_num - 5'd3);

   always_comb begin
      w_rd   = '0;
      w_impl = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:                       w_rd = r_mstatus;
         CSR_MISA:                          w_rd = MISA_VALUE;
         CSR_MIE:                           w_rd = r_mie;
         CSR_MTVEC:                         w_rd = r_mtvec;
         CSR_MCOUNTINHIBIT:                 w_rd = r_mcountinhibit;
         CSR_MSCRATCH:                      w_rd = r_mscratch;
         CSR_MEPC:                          w_rd = r_mepc;
         CSR_MCAUSE:                        w_rd = r_mcause;
         CSR_MTVAL:                         w_rd = r_mtval;
         CSR_MIP:                           w_rd = w_mip;
         CSR_MCYCLE, CSR_CYCLE, CSR_TIME:   w_rd = w_mcycle[31:0];
         CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH: w_rd = w_mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:         w_rd = w_minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH:       w_rd = w_minstret[63:32];
         CSR_MHARTID:                       w_rd = 32'(HART_ID);
         default: begin
            // mhpmevent (0x32x), mhpmcounter (0xB0x/0xB8x) and user aliases share index decode
            if (w_hpm_ok) begin
               case (csr_addr[11:5])
                  7'h19:        w_rd = w_hpm_evt[w_hpm_sel];
                  7'h58, 7'h60: w_rd = w_hpm_val[w_hpm_sel][31:0];
                  7'h5C, 7'h64: w_rd = w_hpm_val[w_hpm_sel][63:32];
                  default:      w_impl = 1'b0;
               endcase
            end else begin
               w_impl = 1'b0;
            end
         end
      endcase
   end

   assign csr_rdata   = w_rd;
   assign w_we        = csr_valid && ((csr_op == CSR_OP_RW) ||
                        ((csr_op != CSR_OP_NONE) && (csr_wsrc != '0)));
   assign csr_illegal = csr_valid && (!w_impl || (w_we && (csr_addr[11:10] == 2'b11)));
   assign w_wr        = w_we && !csr_illegal && !trap_taken && !mret_taken;
   assign w_new       = csr_apply_op(csr_op_e'(csr_op), w_rd, csr_wsrc);
   assign w_mtvec_new = {w_new[31:2], (VECTORED_EN && (w_new[1:0] == 2'b01)) ? 2'b01 : 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mstatus       <= '0;
         r_mie           <= '0;
         r_mtvec         <= '0;
         r_mscratch      <= '0;
         r_mepc          <= '0;
         r_mcause        <= '0;
         r_mtval         <= '0;
         r_mcountinhibit <= '0;
      end else if (trap_taken) begin
         r_mepc                                   <= trap_pc & ~32'h3;
         r_mcause                                 <= trap_cause;
         r_mtval                                  <= trap_tval;
         r_mstatus[MSTATUS_MPIE]                  <= r_mstatus[MSTATUS_MIE];
         r_mstatus[MSTATUS_MIE]                   <= 1'b0;
         r_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
      end else if (mret_taken) begin
         r_mstatus[MSTATUS_MIE]                   <= r_mstatus[MSTATUS_MPIE];
         r_mstatus[MSTATUS_MPIE]                  <= 1'b1;
         r_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b00;
      end else if (w_wr) begin
         case (csr_addr)
            CSR_MSTATUS:       r_mstatus       <= w_new & MSTATUS_MASK;
            CSR_MIE:           r_mie           <= w_new & MIE_MASK;
            CSR_MTVEC:         r_mtvec         <= w_mtvec_new;
            CSR_MCOUNTINHIBIT: r_mcountinhibit <= w_new & INHIBIT_MASK;
            CSR_MSCRATCH:      r_mscratch      <= w_new;
            CSR_MEPC:          r_mepc          <= w_new;
            CSR_MCAUSE:        r_mcause        <= w_new;
            CSR_MTVAL:         r_mtval         <= w_new;
            default:           ;
         endcase
      end
   end

   csr_counter #(.COUNTER_W(COUNTER_W)) u_mcycle (
      .i_clk(clk), .i_rst(rst), .i_inhibit(r_mcountinhibit[0]), .i_inc(1'b1),
      .i_wr_lo(w_wr && (csr_addr == CSR_MCYCLE)), .i_wr_hi(w_wr && (csr_addr == CSR_MCYCLEH)),
      .i_wdata(w_new), .o_value(w_mcycle));

   csr_counter #(.COUNTER_W(COUNTER_W)) u_minstret (
      .i_clk(clk), .i_rst(rst), .i_inhibit(r_mcountinhibit[2]), .i_inc(retire_inst),
      .i_wr_lo(w_wr && (csr_addr == CSR_MINSTRET)), .i_wr_hi(w_wr && (csr_addr == CSR_MINSTRETH)),
      .i_wdata(w_new), .o_value(w_minstret));

`ifdef CSR_HPM_EN
   for (genvar i = 0; i < 8; i++) begin : g_hpm
      if (i < NUM_HPM) begin : g_on
         logic [31:0] r_evt;
         always_ff @(posedge clk) begin
            if (rst) r_evt <= '0;
            else if (w_wr && (csr_addr == CSR_MHPMEVENT3 + 12'(i))) r_evt <= w_new;
         end
         csr_counter #(.COUNTER_W(COUNTER_W)) u_hpm (
            .i_clk(clk), .i_rst(rst), .i_inhibit(r_mcountinhibit[3+i]),
            .i_inc((|r_evt) && hpm_event[i]),
            .i_wr_lo(w_wr && (csr_addr == CSR_MHPMCOUNTER3 + 12'(i))),
            .i_wr_hi(w_wr && (csr_addr == CSR_MHPMCOUNTER3H + 12'(i))),
            .i_wdata(w_new), .o_value(w_hpm_val[i]));
         assign w_hpm_evt[i] = r_evt;
      end else begin : g_off
         assign w_hpm_val[i] = '0;
         assign w_hpm_evt[i] = '0;
      end
   end
`else
   logic w_unused;
   assign w_unused = ^hpm_event;
   for (genvar i = 0; i < 8; i++) begin : g_hpm
      assign w_hpm_val[i] = '0;
      assign w_hpm_evt[i] = '0;
   end
`endif

   assign w_pend            = w_mip & r_mie;
   assign interrupt_pending = r_mstatus[MSTATUS_MIE] && (|w_pend);

   always_comb begin
      interrupt_cause = '0;
      if (r_mstatus[MSTATUS_MIE]) begin
         if (w_pend[MIP_MEIP])      interrupt_cause = CAUSE_MEI;
         else if (w_pend[MIP_MSIP]) interrupt_cause = CAUSE_MSI;
         else if (w_pend[MIP_MTIP]) interrupt_cause = CAUSE_MTI;
      end
   end

   assign w_base      = {r_mtvec[31:2], 2'b00};
   assign trap_vector = ((r_mtvec[1:0] == 2'b01) && interrupt_cause[31])
                      ? w_base + {25'd0, interrupt_cause[4:0], 2'b00} : w_base;
   assign mepc_out    = r_mepc;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: vector table plus hand-written
// trap, interrupt, counter and reset sequences.
module tb_csr_unit;

   logic        clk = 1'b0;
   logic        rst, csr_valid, csr_illegal, trap_taken, mret_taken, retire_inst;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [31:0] csr_wsrc, csr_rdata, trap_cause, trap_pc, trap_tval;
   logic [3:0]  hpm_event;
   logic        timer_irq, software_irq, external_irq, interrupt_pending;
   logic [31:0] interrupt_cause, trap_vector, mepc_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #50 clk = ~clk;

   csr_unit #(.HART_ID(0), .NUM_HPM(4), .COUNTER_W(64), .VECTORED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
      .csr_wsrc(csr_wsrc), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .trap_taken(trap_taken), .trap_cause(trap_cause), .trap_pc(trap_pc),
      .trap_tval(trap_tval), .mret_taken(mret_taken), .retire_inst(retire_inst),
      .hpm_event(hpm_event), .timer_irq(timer_irq), .software_irq(software_irq),
      .external_irq(external_irq), .interrupt_pending(interrupt_pending),
      .interrupt_cause(interrupt_cause), .trap_vector(trap_vector), .mepc_out(mepc_out));

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wsrc;
      logic [31:0] exp_old;
      logic        exp_ill;
      logic        rb;
      logic [31:0] exp_rb;
   } vec_t;

   vec_t tbl [21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wsrc,
                         output logic [31:0] old, output logic ill);
      csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wsrc = wsrc;
      #1;
      old = csr_rdata; ill = csr_illegal;
      tick();
      csr_valid = 1'b0; csr_op = 2'b00; csr_wsrc = '0;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      logic [31:0] o;
      logic        il;
      csr_wr(2'b01, addr, data, o, il);
   endtask

   task automatic chk_rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
      csr_valid = 1'b1; csr_op = 2'b10; csr_addr = addr; csr_wsrc = '0;
      #1;
      check(name, csr_rdata, exp);
      csr_valid = 1'b0; csr_op = 2'b00;
   endtask

   initial begin
      logic [31:0] v;
      logic        il;
      logic [31:0] hpm_exp, evt_exp;

      rst = 1'b1; csr_valid = 1'b0; csr_addr = '0; csr_op = 2'b00; csr_wsrc = '0;
      trap_taken = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0; mret_taken = 1'b0;
      retire_inst = 1'b0; hpm_event = '0; timer_irq = 1'b0; software_irq = 1'b0;
      external_irq = 1'b0;
      tick(); tick();
      rst = 1'b0;

      check("rst_pending", 32'(interrupt_pending), 32'h0);
      check("rst_cause", interrupt_cause, 32'h0);
      check("rst_tvec", trap_vector, 32'h0);
      check("rst_mepc", mepc_out, 32'h0);
      chk_rd("rst_mstatus", 12'h300, 32'h0);
      chk_rd("rst_misa", 12'h301, 32'h4000_0100);
      chk_rd("rst_mhartid", 12'hF14, 32'h0);

      tbl[0]  = '{2'b01, 12'h340, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
      tbl[1]  = '{2'b10, 12'h340, 32'h00000010, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEFF};
      tbl[2]  = '{2'b11, 12'h340, 32'hFFFF0000, 32'hDEADBEFF, 1'b0, 1'b1, 32'h0000BEFF};
      tbl[3]  = '{2'b11, 12'h340, 32'h0,        32'h0000BEFF, 1'b0, 1'b1, 32'h0000BEFF};
      tbl[4]  = '{2'b00, 12'h340, 32'h00000001, 32'h0000BEFF, 1'b0, 1'b1, 32'h0000BEFF};
      tbl[5]  = '{2'b01, 12'h300, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 32'h00001888};
      tbl[6]  = '{2'b11, 12'h300, 32'hFFFFFFFF, 32'h00001888, 1'b0, 1'b1, 32'h0};
      tbl[7]  = '{2'b01, 12'h304, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 32'h00000888};
      tbl[8]  = '{2'b01, 12'h304, 32'h0,        32'h00000888, 1'b0, 1'b1, 32'h0};
      tbl[9]  = '{2'b01, 12'h305, 32'h00001003, 32'h0,        1'b0, 1'b1, 32'h00001000};
      tbl[10] = '{2'b10, 12'h305, 32'h00000001, 32'h00001000, 1'b0, 1'b1, 32'h00001001};
      tbl[11] = '{2'b01, 12'h305, 32'h00000002, 32'h00001001, 1'b0, 1'b1, 32'h0};
      tbl[12] = '{2'b01, 12'h344, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 32'h0};
      tbl[13] = '{2'b01, 12'h301, 32'h0,        32'h40000100, 1'b0, 1'b1, 32'h40000100};
      tbl[14] = '{2'b10, 12'hF14, 32'h00000001, 32'h0,        1'b1, 1'b1, 32'h0};
      tbl[15] = '{2'b10, 12'hF14, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0};
      tbl[16] = '{2'b01, 12'hF14, 32'h00000055, 32'h0,        1'b1, 1'b1, 32'h0};
      tbl[17] = '{2'b01, 12'h7C0, 32'h00000001, 32'h0,        1'b1, 1'b0, 32'h0};
      tbl[18] = '{2'b01, 12'h341, 32'h00001235, 32'h0,        1'b0, 1'b1, 32'h00001235};
      tbl[19] = '{2'b01, 12'h342, 32'h8000000B, 32'h0,        1'b0, 1'b1, 32'h8000000B};
      tbl[20] = '{2'b01, 12'h343, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};

      for (int i = 0; i < 21; i++) begin
         csr_wr(tbl[i].op, tbl[i].addr, tbl[i].wsrc, v, il);
         check($sformatf("vec%0d_old", i), v, tbl[i].exp_old);
         check($sformatf("vec%0d_ill", i), 32'(il), 32'(tbl[i].exp_ill));
         if (tbl[i].rb) chk_rd($sformatf("vec%0d_rb", i), tbl[i].addr, tbl[i].exp_rb);
      end
      check("mepc_out_wr", mepc_out, 32'h00001235);

      // interrupt arbitration and vectoring
      wr(12'h304, 32'h80);
      wr(12'h300, 32'h8);
      wr(12'h305, 32'h80000101);
      timer_irq = 1'b1;
      #1;
      check("mti_pending", 32'(interrupt_pending), 32'h1);
      check("mti_cause", interrupt_cause, 32'h80000007);
      check("mti_vec_101", trap_vector, 32'h8000011C);
      chk_rd("mip_timer", 12'h344, 32'h80);
      wr(12'h305, 32'h80000001);
      check("mti_vec_001", trap_vector, 32'h8000001C);
      wr(12'h304, 32'h888);
      software_irq = 1'b1;
      #1;
      check("msi_cause", interrupt_cause, 32'h80000003);
      check("msi_vec", trap_vector, 32'h8000000C);
      external_irq = 1'b1;
      #1;
      check("mei_cause", interrupt_cause, 32'h8000000B);
      check("mei_vec", trap_vector, 32'h8000002C);
      wr(12'h305, 32'h80000000);
      check("direct_vec", trap_vector, 32'h80000000);
      wr(12'h300, 32'h0);
      check("mie_off_pending", 32'(interrupt_pending), 32'h0);
      timer_irq = 1'b0; software_irq = 1'b0; external_irq = 1'b0;
      wr(12'h304, 32'h0);

      // trap beats a same-cycle CSR write; mret beats a same-cycle write
      wr(12'h300, 32'h8);
      trap_taken = 1'b1; trap_pc = 32'h203; trap_cause = 32'h2; trap_tval = 32'h77;
      wr(12'h341, 32'h1234);
      trap_taken = 1'b0;
      check("trap_mepc", mepc_out, 32'h200);
      chk_rd("trap_mcause", 12'h342, 32'h2);
      chk_rd("trap_mtval", 12'h343, 32'h77);
      chk_rd("trap_mstatus", 12'h300, 32'h1880);
      mret_taken = 1'b1;
      wr(12'h300, 32'h0);
      mret_taken = 1'b0;
      chk_rd("mret_mstatus", 12'h300, 32'h88);
      check("mret_mepc", mepc_out, 32'h200);

      // mcycle carry across halves, then wrap
      wr(12'hB00, 32'hFFFFFFFF);
      wr(12'hB80, 32'h0);
      chk_rd("cyc_hold_lo", 12'hC00, 32'hFFFFFFFF);
      chk_rd("cyc_hold_hi", 12'hC80, 32'h0);
      tick();
      chk_rd("cyc_carry_hi", 12'hC80, 32'h1);
      chk_rd("cyc_carry_lo", 12'hC00, 32'h0);
      tick();
      chk_rd("cyc_inc_lo", 12'hB00, 32'h1);
      chk_rd("time_alias", 12'hC01, 32'h1);
      wr(12'hB00, 32'hFFFFFFFF);
      wr(12'hB80, 32'hFFFFFFFF);
      tick();
      chk_rd("cyc_wrap_lo", 12'hC00, 32'h0);
      chk_rd("cyc_wrap_hi", 12'hC80, 32'h0);

      // minstret counting and inhibit
      wr(12'hB02, 32'h0);
      wr(12'hB82, 32'h0);
      retire_inst = 1'b1;
      tick(); tick(); tick();
      retire_inst = 1'b0;
      chk_rd("instret_3", 12'hC02, 32'h3);
      wr(12'h320, 32'h5);
      wr(12'hB00, 32'd100);
      wr(12'hB80, 32'h0);
      wr(12'hB02, 32'd50);
      wr(12'hB82, 32'h0);
      retire_inst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      retire_inst = 1'b0;
      chk_rd("inh_cycle", 12'hC00, 32'd100);
      chk_rd("inh_instret", 12'hC02, 32'd50);
      wr(12'h320, 32'h0);
      tick(); tick();
      chk_rd("uninh_cycle", 12'hC00, 32'd102);

      // hardware performance counters
`ifdef CSR_HPM_EN
      hpm_exp = 32'd5;
      evt_exp = 32'd1;
`else
      hpm_exp = 32'd0;
      evt_exp = 32'd0;
`endif
      csr_wr(2'b01, 12'h323, 32'h1, v, il);
      check("hpmevt_ill", 32'(il), 32'h0);
      hpm_event = 4'b0011;
      for (int i = 0; i < 5; i++) tick();
      hpm_event = 4'b0000;
      tick();
      chk_rd("hpm3_m", 12'hB03, hpm_exp);
      chk_rd("hpm3_u", 12'hC03, hpm_exp);
      chk_rd("hpm3_h", 12'hB83, 32'h0);
      chk_rd("hpm4_noevt", 12'hB04, 32'h0);
      chk_rd("hpmevt3", 12'h323, evt_exp);

      // reset wins over concurrent trap and write
      rst = 1'b1; trap_taken = 1'b1; trap_pc = 32'h400;
      wr(12'h340, 32'h1234);
      rst = 1'b0; trap_taken = 1'b0;
      chk_rd("rstw_mscratch", 12'h340, 32'h0);
      chk_rd("rstw_mstatus", 12'h300, 32'h0);
      chk_rd("rstw_cycle", 12'hC00, 32'h0);
      check("rstw_mepc", mepc_out, 32'h0);
      check("rstw_tvec", trap_vector, 32'h0);
      check("rstw_pending", 32'(interrupt_pending), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
